// File: rtl/rf_read_streamer.sv
// rf_read_streamer: credit-gated block-read sequencer for the vector register file,
// buffering fixed-latency read data in a small FIFO for a backpressurable output stream.
module rf_read_streamer #(
   parameter int DATAW      = 8,
   parameter int LANES      = 40,
   parameter int DEPTH      = 512,
   parameter int ADDRW      = $clog2(DEPTH),
   parameter int LENW       = ADDRW + 1,
   parameter int RF_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDRW-1:0]        i_cmd_addr,
   input  logic [LENW-1:0]         i_cmd_len,
   input  logic                    i_cmd_load,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   output logic [ADDRW-1:0]        o_rf_raddr,
   output logic                    o_rf_rvalid,
   output logic                    o_rf_rload,
   input  logic signed [DATAW-1:0] i_rf_rdata [0:LANES-1],
   input  logic                    i_rf_rvalid,
   input  logic                    i_rf_rload,
   output logic signed [DATAW-1:0] o_data [0:LANES-1],
   output logic                    o_load,
   output logic                    o_last,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_busy
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t                  r_state, w_next;
   logic [ADDRW-1:0]        r_addr;
   logic [LENW-1:0]         r_rem;
   logic                    r_load;
   logic [CW-1:0]           r_inflight, r_occ;
   logic [RF_LATENCY-1:0]   r_last_pipe;
   logic signed [DATAW-1:0] r_mem [FIFO_DEPTH][LANES];
   logic [FIFO_DEPTH-1:0]   r_mem_load, r_mem_last;
   logic [PW-1:0]           r_wptr, r_rptr;
   logic                    w_accept, w_issue, w_last_issue, w_push, w_pop;
   logic [CW:0]             w_used;
   // Words already claimed: buffered plus still travelling through the register file
   assign w_used       = {1'b0, r_occ} + {1'b0, r_inflight};
   assign w_issue      = (r_state == ISSUE) && (w_used < (CW+1)'(FIFO_DEPTH));
   assign w_last_issue = w_issue && (r_rem == LENW'(1));
   assign w_accept     = (r_state == IDLE) && i_cmd_valid;
   assign w_push       = i_rf_rvalid;
   assign w_pop        = o_valid && i_ready;
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? ((i_cmd_valid && i_cmd_len != '0) ? ISSUE : IDLE)
                                 : (w_last_issue ? IDLE : ISSUE);
   always_comb begin
      o_cmd_ready = (r_state == IDLE);
      o_rf_rvalid = w_issue;
      o_rf_raddr  = r_addr;
      o_rf_rload  = r_load;
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_addr <= '0;
         r_rem  <= '0;
         r_load <= 1'b0;
      end else if (w_accept && i_cmd_len != '0) begin
         r_addr <= i_cmd_addr;
         r_rem  <= i_cmd_len;
         r_load <= i_cmd_load;
      end else if (w_issue) begin
         r_addr <= (r_addr == ADDRW'(DEPTH-1)) ? '0 : r_addr + 1'b1;
         r_rem  <= r_rem - 1'b1;
      end
   always_ff @(posedge clk)
      if (rst) begin
         r_inflight  <= '0;
         r_occ       <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_last_pipe <= '0;
      end else begin
         r_inflight  <= r_inflight + CW'(w_issue) - CW'(w_push);
         r_occ       <= r_occ + CW'(w_push) - CW'(w_pop);
         r_last_pipe <= (r_last_pipe << 1) | RF_LATENCY'(w_last_issue);
         if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wptr + 1'b1;
         if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (w_push) begin
         for (int j = 0; j < LANES; j++) r_mem[r_wptr][j] <= i_rf_rdata[j];
         r_mem_load[r_wptr] <= i_rf_rload;
         r_mem_last[r_wptr] <= r_last_pipe[RF_LATENCY-1];
      end
   always_comb begin
      for (int j = 0; j < LANES; j++) o_data[j] = r_mem[r_rptr][j];
      o_load  = r_mem_load[r_rptr];
      o_last  = r_mem_last[r_rptr];
      o_valid = (r_occ != '0);
      o_busy  = (r_state != IDLE) || (r_inflight != '0) || (r_occ != '0);
   end
endmodule
